aes_inv_cipher_controller: RTL and testbench

- Sequencing controller for the AES decryption datapath (inverse cipher); the counterpart of the encryption round controller.
- Runs a one-time forward key expansion that fills the round-key store, then applies the round keys in reverse order: NR first, down to 0.
- Drives the inverse-round datapath strobes.
- Provides a start/ready request handshake and a valid/ack result handshake.

---
 rtl/aes_inv_cipher_controller.sv | 127 ++++++++++++
 tb/tb_aes_inv_cipher_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_controller.sv
// Purpose : sequencing controller for the AES inverse cipher (key expansion, then rounds NR..0).
// Latency : start->decipher_valid = NR+2 cycles with a cached key, 2*NR+2 with key expansion.
// Backpr. : start accepted only while decipher_ready; result held in DONE until out_ack.
//
// Ports:
//   clk, rst_n            - clock (rising edge), asynchronous active-low reset
//   start, key_load       - request (sampled in IDLE only); key_load forces key expansion
//   out_ack               - consumer took the plaintext (sampled in DONE only)
//   decipher_ready/valid  - request / result handshake
//   kexp_en, kexp_round   - round-key generation strobe and index (1..NR)
//   load_state            - load ciphertext and add round key NR
//   round_en, last_round  - inverse round strobe; last_round skips InvMixColumns
//   round_num             - current inverse round, also the round-key read address
module aes_inv_cipher_controller #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          key_load,
    input  logic          out_ack,
    output logic          decipher_ready,
    output logic          decipher_valid,
    output logic          kexp_en,
    output logic [RW-1:0] kexp_round,
    output logic          load_state,
    output logic          round_en,
    output logic          last_round,
    output logic [RW-1:0] round_num
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        LOAD  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [RW-1:0] NR_W    = RW'(NR);
    localparam logic [RW-1:0] NR_M1_W = RW'(NR - 1);

    state_t        state, state_nxt;
    logic          key_valid, key_valid_nxt;
    logic [RW-1:0] round_q, round_nxt;
    logic [RW-1:0] kexp_q, kexp_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_valid <= 1'b0;
            round_q   <= '0;
            kexp_q    <= '0;
        end else begin
            state     <= state_nxt;
            key_valid <= key_valid_nxt;
            round_q   <= round_nxt;
            kexp_q    <= kexp_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        key_valid_nxt = key_valid;
        round_nxt     = round_q;
        kexp_nxt      = kexp_q;
        case (state)
            IDLE: begin
                if (start) begin
                    // A fresh key, or no key ever expanded since reset, needs the schedule run.
                    if (key_load || !key_valid) begin
                        state_nxt = KEXP;
                        kexp_nxt  = RW'(1);
                    end else begin
                        state_nxt = LOAD;
                        round_nxt = NR_W;
                    end
                end
            end
            KEXP: begin
                if (kexp_q == NR_W) begin
                    state_nxt     = LOAD;
                    key_valid_nxt = 1'b1;
                    kexp_nxt      = '0;
                    round_nxt     = NR_W;
                end else begin
                    kexp_nxt = kexp_q + RW'(1);
                end
            end
            LOAD: begin
                state_nxt = ROUND;
                round_nxt = NR_M1_W;
            end
            ROUND: begin
                // Round 0 is the final one; the counter parks at 0 rather than wrapping.
                if (round_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    round_nxt = round_q - RW'(1);
                end
            end
            DONE: begin
                if (out_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode only flopped state/counters, so inputs never reach them combinationally.
    always_comb begin
        decipher_ready = (state == IDLE);
        decipher_valid = (state == DONE);
        kexp_en        = (state == KEXP);
        load_state     = (state == LOAD);
        round_en       = (state == ROUND);
        last_round     = (state == ROUND) && (round_q == '0);
    end

    assign kexp_round = kexp_q;
    assign round_num  = round_q;

endmodule

// File: tb/tb_aes_inv_cipher_controller.sv
module tb_aes_inv_cipher_controller;

    localparam int NR = 10;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic start, key_load, out_ack;
    logic decipher_ready, decipher_valid, kexp_en, load_state, round_en, last_round;
    logic [RW-1:0] kexp_round, round_num;

    logic start14, key_load14, out_ack14;
    logic r14_ready, r14_valid, r14_kexp_en, r14_load, r14_round_en, r14_last;
    logic [3:0] r14_kexp_round, r14_round_num;

    int checks = 0;
    int passed = 0;
    bit model_kv = 1'b0;

    always #5 clk = ~clk;

    aes_inv_cipher_controller #(.NR(NR), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_load(key_load), .out_ack(out_ack),
        .decipher_ready(decipher_ready), .decipher_valid(decipher_valid),
        .kexp_en(kexp_en), .kexp_round(kexp_round), .load_state(load_state),
        .round_en(round_en), .last_round(last_round), .round_num(round_num)
    );

    aes_inv_cipher_controller #(.NR(14), .RW(4)) dut14 (
        .clk(clk), .rst_n(rst_n), .start(start14), .key_load(key_load14), .out_ack(out_ack14),
        .decipher_ready(r14_ready), .decipher_valid(r14_valid),
        .kexp_en(r14_kexp_en), .kexp_round(r14_kexp_round), .load_state(r14_load),
        .round_en(r14_round_en), .last_round(r14_last), .round_num(r14_round_num)
    );

    // Observed output vector: {ready, valid, kexp_en, kexp_round, load, round_en, last, round_num}
    wire [13:0] obs   = {decipher_ready, decipher_valid, kexp_en, kexp_round,
                         load_state, round_en, last_round, round_num};
    wire [13:0] obs14 = {r14_ready, r14_valid, r14_kexp_en, r14_kexp_round,
                         r14_load, r14_round_en, r14_last, r14_round_num};

    // Reference timeline: expected outputs k cycles after start was sampled (k=0: idle).
    function automatic logic [13:0] exp_out(input int nr, input bit kx, input int k);
        bit rdy = 0, vld = 0, ke = 0, ls = 0, re = 0, lr = 0;
        int kr = 0, rn = 0;
        int off = kx ? nr : 0;
        if (k == 0) rdy = 1;
        else if (kx && k <= nr) begin ke = 1; kr = k; end
        else if (k == off + 1) begin ls = 1; rn = nr; end
        else if (k <= off + nr + 1) begin re = 1; rn = nr - (k - off - 1); lr = (rn == 0); end
        else vld = 1;
        return {rdy, vld, ke, 4'(kr), ls, re, lr, 4'(rn)};
    endfunction

    // ---------------- behavioural AES-128 datapath driven by the strobes ----------------
    logic [7:0]   sbox [256];
    logic [7:0]   isbox[256];
    logic [127:0] rk   [0:15];
    logic [127:0] st;
    logic [127:0] tb_key, tb_ct;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] key_step(input logic [127:0] prev, input int idx);
        logic [7:0]  rc = 8'h01;
        logic [31:0] w3, rot, t, n0, n1, n2, n3;
        for (int j = 1; j < idx; j++) rc = xt(rc);
        w3  = prev[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox[rot[31:24]], sbox[rot[23:16]], sbox[rot[15:8]], sbox[rot[7:0]]} ^ {rc, 24'h0};
        n0  = prev[127:96] ^ t;
        n1  = prev[95:64] ^ n0;
        n2  = prev[63:32] ^ n1;
        n3  = prev[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input bit last);
        logic [7:0] b[16], nb[16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
        for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++)
                nb[rr+4*c] = isbox[b[rr+4*((c-rr+4)%4)]] ^ k[127-8*(rr+4*c) -: 8];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = nb[4*c]; a1 = nb[4*c+1]; a2 = nb[4*c+2]; a3 = nb[4*c+3];
                nb[4*c]   = gm(a0, 8'd14) ^ gm(a1, 8'd11) ^ gm(a2, 8'd13) ^ gm(a3, 8'd9);
                nb[4*c+1] = gm(a0, 8'd9)  ^ gm(a1, 8'd14) ^ gm(a2, 8'd11) ^ gm(a3, 8'd13);
                nb[4*c+2] = gm(a0, 8'd13) ^ gm(a1, 8'd9)  ^ gm(a2, 8'd14) ^ gm(a3, 8'd11);
                nb[4*c+3] = gm(a0, 8'd11) ^ gm(a1, 8'd13) ^ gm(a2, 8'd9)  ^ gm(a3, 8'd14);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = nb[i];
        return r;
    endfunction

    always @(posedge clk) begin
        if (kexp_en) begin
            if (kexp_round == 4'd1) rk[0] = tb_key;
            rk[kexp_round] = key_step(rk[4'(kexp_round - 4'd1)], int'(kexp_round));
        end
        if (load_state) st = tb_ct ^ rk[round_num];
        if (round_en)   st = inv_round(st, rk[round_num], last_round);
    end

    // ---------------- scenario driver for the NR=10 instance ----------------
    task automatic run_op(input string name, input bit kl, input int ack_dly, input bit noise,
                          input int abort_rn, input bit chk_pt, input logic [127:0] exp_pt);
        bit kx;
        int total;
        logic [13:0] e;
        kx    = kl || !model_kv;
        total = (kx ? NR : 0) + NR + 2;
        @(negedge clk);
        e = exp_out(NR, kx, 0);
        checks++;
        if (obs !== e) $display("FAIL %s idle-before got %b exp %b", name, obs, e);
        else passed++;
        start = 1'b1; key_load = kl;
        @(posedge clk);
        #1 start = 1'b0; key_load = 1'b0;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            e = exp_out(NR, kx, k);
            checks++;
            if (obs !== e) $display("FAIL %s trace k=%0d got %b exp %b", name, k, obs, e);
            else passed++;
            if (abort_rn >= 0 && e[5] && int'(e[3:0]) == abort_rn) begin
                rst_n = 1'b0;
                #1;
                e = exp_out(NR, 1'b0, 0);
                checks++;
                if (obs !== e) $display("FAIL %s async-reset got %b exp %b", name, obs, e);
                else passed++;
                model_kv = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (noise && k < total) begin
                start    = 1'($urandom_range(0, 1));
                key_load = 1'($urandom_range(0, 1));
                out_ack  = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0; key_load = 1'b0; out_ack = 1'b0;
            end
        end
        model_kv = 1'b1;
        if (chk_pt) begin
            checks++;
            if (st !== exp_pt) $display("FAIL %s plaintext got %h exp %h", name, st, exp_pt);
            else passed++;
        end
        e = exp_out(NR, kx, total);
        for (int d = 0; d < ack_dly; d++) begin
            @(negedge clk);
            checks++;
            if (obs !== e) $display("FAIL %s hold d=%0d got %b exp %b", name, d, obs, e);
            else passed++;
        end
        out_ack = 1'b1;
        e = exp_out(NR, kx, 0);
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            out_ack = 1'b0;
            checks++;
            if (obs !== e) $display("FAIL %s idle-after d=%0d got %b exp %b", name, d, obs, e);
            else passed++;
        end
    endtask

    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

    task automatic test_reset();
        logic [13:0] e;
        e = exp_out(NR, 1'b0, 0);
        @(negedge clk);
        checks++;
        if (obs !== e) $display("FAIL reset_hold got %b exp %b", obs, e);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== e) $display("FAIL reset_release got %b exp %b", obs, e);
        else passed++;
        checks++;
        if (obs14 !== exp_out(14, 1'b0, 0)) $display("FAIL reset_nr14 got %b", obs14);
        else passed++;
    endtask

    task automatic test_key_expansion();
        run_op("kexp_first", 1'b1, 1, 1'b0, -1, 1'b1, PT);
    endtask

    task automatic test_cached_key_hold();
        run_op("cached_hold", 1'b0, 5, 1'b0, -1, 1'b1, PT);
    endtask

    task automatic test_ignored_requests();
        run_op("noise_kexp", 1'b1, 2, 1'b1, -1, 1'b1, PT);
        run_op("noise_cached", 1'b0, 0, 1'b1, -1, 1'b1, PT);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_op("random_op", 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)), -1, 1'b1, PT);
    endtask

    task automatic test_reset_mid_round();
        run_op("abort_round5", 1'b0, 0, 1'b0, 5, 1'b0, PT);
        run_op("after_abort", 1'b0, 1, 1'b0, -1, 1'b1, PT);
    endtask

    task automatic test_nr14();
        logic [13:0] e;
        @(negedge clk);
        start14 = 1'b1; key_load14 = 1'b1;
        @(posedge clk);
        #1 start14 = 1'b0; key_load14 = 1'b0;
        for (int k = 1; k <= 2 * 14 + 2; k++) begin
            @(negedge clk);
            e = exp_out(14, 1'b1, k);
            checks++;
            if (obs14 !== e) $display("FAIL nr14 trace k=%0d got %b exp %b", k, obs14, e);
            else passed++;
        end
        out_ack14 = 1'b1;
        @(negedge clk);
        out_ack14 = 1'b0;
        e = exp_out(14, 1'b0, 0);
        checks++;
        if (obs14 !== e) $display("FAIL nr14 idle-after got %b exp %b", obs14, e);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; key_load = 1'b0; out_ack = 1'b0;
        start14 = 1'b0; key_load14 = 1'b0; out_ack14 = 1'b0;
        tb_key = KEY;
        tb_ct  = CT;
        st     = '0;
        for (int i = 0; i < 16; i++) rk[i] = '0;
        build_tables();
        test_reset();
        test_key_expansion();
        test_cached_key_hold();
        test_ignored_requests();
        test_back_to_back();
        test_reset_mid_round();
        test_nr14();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
